// File: rtl/nc_pkg.sv
// Shared LFSR constants, scheduler state encoding and the LFSR next-state helper.
// Optional feature macro used by the design: LFSR_SEED_LOAD_EN.
package nc_pkg;

    localparam int                LFSR_W       = 13;
    localparam logic [LFSR_W-1:0] LFSR_TAPS    = 13'h1C80;
    localparam logic [LFSR_W-1:0] DEFAULT_SEED = 13'h1ACE;

    typedef enum logic [1:0] {
        IDLE,
        GEN,
        DONE
    } state_e;

    // Shift left, feedback is the XOR of the tapped bits (12,11,10,7).
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] l);
        return {l[LFSR_W-2:0], ^(l & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/lfsr13_core.sv
// 13-bit maximal-length Fibonacci LFSR with load, all-zero recovery and a
// wrap pulse one cycle after a step lands the state back on SEED.
// A load of zero is replaced by SEED (used when LFSR_SEED_LOAD_EN is defined).
module lfsr13_core
    import nc_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              step,
    input  logic              load,
    input  logic [LFSR_W-1:0] load_val,
    output logic [LFSR_W-1:0] state,
    output logic              out_bit,
    output logic              wrap
);

    logic [LFSR_W-1:0] state_q, state_d;
    logic              stepped_q, stepped_d;
    logic              wrap_q, wrap_d;

    // Next state: load beats zero recovery beats stepping; only a real step arms the wrap detector.
    always_comb begin
        state_d   = state_q;
        stepped_d = 1'b0;
        wrap_d    = stepped_q && (state_q == SEED);
        if (load) begin
            state_d = (load_val == '0) ? SEED : load_val;
        end else if (state_q == '0) begin
            state_d = SEED;
        end else if (step) begin
            state_d   = lfsr_next(state_q);
            stepped_d = 1'b1;
        end
    end

    // State register with asynchronous active-low reset back to SEED.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= SEED;
            stepped_q <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            stepped_q <= stepped_d;
            wrap_q    <= wrap_d;
        end
    end

    assign state   = state_q;
    assign out_bit = state_q[LFSR_W-1];
    assign wrap    = wrap_q;

endmodule

// File: rtl/lfsr_vec_sched.sv
// Round-robin scheduler sharing one 13-bit LFSR among NREQ requesters; each
// grant collects VEC_W LFSR output bits (first bit ends up as MSB).
// Optional macro LFSR_SEED_LOAD_EN adds seed_load/seed_in (honoured in IDLE only).
module lfsr_vec_sched
    import nc_pkg::*;
#(
    parameter int                NREQ  = 2,
    parameter int                VEC_W = 16,
    parameter logic [LFSR_W-1:0] SEED  = DEFAULT_SEED
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
`ifdef LFSR_SEED_LOAD_EN
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed_in,
`endif
    output logic [NREQ-1:0]   gnt,
    output logic [VEC_W-1:0]  vec,
    output logic              vec_valid,
    output logic [LFSR_W-1:0] lfsr,
    output logic              lfsr_done
);

    localparam int PTR_W = $clog2(NREQ);
    localparam int CNT_W = $clog2(VEC_W);

    state_e            state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [VEC_W-1:0]  vec_q, vec_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PTR_W-1:0]  rr_q, rr_d;
    logic [PTR_W-1:0]  owner_q, owner_d;

    logic [PTR_W-1:0]  win_idx;
    logic              win_found;
    int unsigned       idx;

    logic              step;
    logic              load;
    logic [LFSR_W-1:0] load_val;
    logic              out_bit;

`ifdef LFSR_SEED_LOAD_EN
    assign load     = seed_load && (state_q == IDLE);
    assign load_val = seed_in;
`else
    assign load     = 1'b0;
    assign load_val = SEED;
`endif

    lfsr13_core #(
        .SEED (SEED)
    ) u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .step     (step),
        .load     (load),
        .load_val (load_val),
        .state    (lfsr),
        .out_bit  (out_bit),
        .wrap     (lfsr_done)
    );

    // Round-robin pick: first set request at or after rr_q, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        idx       = 0;
        for (int unsigned k = 0; k < unsigned'(NREQ); k++) begin
            idx = (32'(rr_q) + k) % unsigned'(NREQ);
            if (!win_found && req[idx[PTR_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = idx[PTR_W-1:0];
            end
        end
    end

    // FSM next-state and outputs: IDLE arbitrates, GEN shifts/steps, DONE presents the vector.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        vec_d     = vec_q;
        cnt_d     = cnt_q;
        rr_d      = rr_q;
        owner_d   = owner_q;
        step      = 1'b0;
        vec_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    owner_d        = win_idx;
                    gnt_d          = '0;
                    gnt_d[win_idx] = 1'b1;
                    cnt_d          = '0;
                    state_d        = GEN;
                end
            end
            GEN: begin
                vec_d = {vec_q[VEC_W-2:0], out_bit};
                step  = 1'b1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(VEC_W - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                vec_valid = 1'b1;
                rr_d      = (owner_q == PTR_W'(NREQ - 1)) ? '0 : owner_q + PTR_W'(1);
                gnt_d     = '0;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // Scheduler registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            vec_q   <= '0;
            cnt_q   <= '0;
            rr_q    <= '0;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
        end
    end

    assign gnt = gnt_q;
    assign vec = vec_q;

endmodule

// File: tb/tb_lfsr_vec_sched.sv
// Self-checking bench for lfsr_vec_sched: table-driven arbitration records,
// a scoreboard of golden-model vectors, and hand-written reset/wrap sequences.
// Seed-load sequence is included when LFSR_SEED_LOAD_EN is defined.
module tb_lfsr_vec_sched;

    localparam int          NREQ   = 2;
    localparam int          VEC_W  = 16;
    localparam logic [12:0] SEED_V = 13'h1ACE;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   gnt;
    logic [VEC_W-1:0]  vec;
    logic              vec_valid;
    logic [12:0]       lfsr;
    logic              lfsr_done;
`ifdef LFSR_SEED_LOAD_EN
    logic              seed_load;
    logic [12:0]       seed_in;
`endif

    always #5 clk = ~clk;

    lfsr_vec_sched #(
        .NREQ  (NREQ),
        .VEC_W (VEC_W),
        .SEED  (SEED_V)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
`ifdef LFSR_SEED_LOAD_EN
        .seed_load (seed_load),
        .seed_in   (seed_in),
`endif
        .gnt       (gnt),
        .vec       (vec),
        .vec_valid (vec_valid),
        .lfsr      (lfsr),
        .lfsr_done (lfsr_done)
    );

    typedef struct {
        logic [1:0] r;
        logic [1:0] eg;
        int         ew;
        bit         drop;
    } vec_rec_t;

    typedef struct {
        logic [1:0]  g;
        logic [15:0] v;
        logic [12:0] s;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [12:0] ml;

    int          done_cnt = 0;
    int          vv_cnt   = 0;
    int          multihot = 0;
    logic [12:0] prev_lfsr = '0;
    logic [12:0] done_prev = '0;
    logic        done_vv   = 1'b0;

    // Passive monitor sampled on the falling edge.
    always @(negedge clk) begin
        if (lfsr_done) begin
            done_cnt++;
            done_prev = prev_lfsr;
            done_vv   = vec_valid;
        end
        if (vec_valid) vv_cnt++;
        if ($countones(gnt) > 1) multihot++;
        prev_lfsr = lfsr;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Golden model: 16 output bits (first as MSB) and the state after 16 steps.
    task automatic model_vec(output logic [15:0] v, output logic [12:0] s);
        v = '0;
        for (int i = 0; i < VEC_W; i++) begin
            v  = {v[14:0], ml[12]};
            ml = {ml[11:0], ml[12] ^ ml[11] ^ ml[10] ^ ml[7]};
        end
        s = ml;
    endtask

    task automatic do_txn(input logic [1:0] r, input logic [1:0] eg, input int ew, input bit drop);
        exp_t        e;
        int          w;
        logic [15:0] v;
        logic [12:0] s;
        req = r;
        model_vec(v, s);
        sb.push_back('{g: eg, v: v, s: s});
        w = 0;
        do begin @(posedge clk); #1; w++; end while (gnt == '0 && w < 40);
        chk("gnt_wait", 32'(w), 32'(ew));
        chk("gnt_owner", 32'(gnt), 32'(eg));
        if (drop) req = '0;
        w = 0;
        do begin @(posedge clk); #1; w++; end while (!vec_valid && w < 40);
        chk("vv_latency", 32'(w), 32'(VEC_W));
        e = sb.pop_front();
        chk("vec", 32'(vec), 32'(e.v));
        chk("lfsr_after", 32'(lfsr), 32'(e.s));
        chk("gnt_at_vv", 32'(gnt), 32'(e.g));
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        req = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        sb.delete();
        ml = SEED_V;
        @(posedge clk); #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vec_rec_t tbl[8];
        int       w;

        tbl[0] = '{r: 2'b01, eg: 2'b01, ew: 1, drop: 0};
        tbl[1] = '{r: 2'b11, eg: 2'b10, ew: 2, drop: 0};
        tbl[2] = '{r: 2'b11, eg: 2'b01, ew: 2, drop: 1};
        tbl[3] = '{r: 2'b10, eg: 2'b10, ew: 2, drop: 0};
        tbl[4] = '{r: 2'b10, eg: 2'b10, ew: 2, drop: 0};
        tbl[5] = '{r: 2'b01, eg: 2'b01, ew: 2, drop: 0};
        tbl[6] = '{r: 2'b01, eg: 2'b01, ew: 2, drop: 0};
        tbl[7] = '{r: 2'b11, eg: 2'b10, ew: 2, drop: 0};

        rst = 1'b0;
        req = '0;
`ifdef LFSR_SEED_LOAD_EN
        seed_load = 1'b0;
        seed_in   = '0;
`endif
        ml = SEED_V;

        // Test 1: reset values
        #100 rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_gnt", 32'(gnt), 32'(0));
        chk("rst_vv", 32'(vec_valid), 32'(0));
        chk("rst_lfsr", 32'(lfsr), 32'(SEED_V));
        chk("rst_done", 32'(lfsr_done), 32'(0));
        chk("rst_vec", 32'(vec), 32'(0));

        // Test 2 and arbitration table (rr pointer starts at 0)
        for (int i = 0; i < 8; i++) begin
            do_txn(tbl[i].r, tbl[i].eg, tbl[i].ew, tbl[i].drop);
        end
        req = '0;
        repeat (3) @(posedge clk);

        // Test 3: both requesting, held; winners 0,1,0 and vectors continue the stream
        do_reset();
        do_txn(2'b11, 2'b01, 1, 0);
        do_txn(2'b11, 2'b10, 2, 0);
        do_txn(2'b11, 2'b01, 2, 0);
        req = '0;
        repeat (3) @(posedge clk);

        // Test 4: reset at GEN cycle 5 discards the partial vector
        do_reset();
        req = 2'b01;
        w = 0;
        do begin @(posedge clk); #1; w++; end while (gnt == '0 && w < 40);
        chk("t4_gnt", 32'(gnt), 32'(2'b01));
        repeat (5) @(posedge clk);
        #1 rst = 1'b0;
        vv_cnt = 0;
        #1;
        chk("t4_gnt_rst", 32'(gnt), 32'(0));
        chk("t4_vec_rst", 32'(vec), 32'(0));
        chk("t4_lfsr_rst", 32'(lfsr), 32'(SEED_V));
        chk("t4_vv_rst", 32'(vec_valid), 32'(0));
        req = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        sb.delete();
        ml = SEED_V;
        repeat (20) @(posedge clk);
        #1;
        chk("t4_no_vv", 32'(vv_cnt), 32'(0));
        do_txn(2'b01, 2'b01, 1, 0);
        req = '0;
        repeat (3) @(posedge clk);

        // Test 5: 512 vectors = 8192 steps; wrap pulse once, coinciding with vec_valid
        do_reset();
        done_cnt = 0;
        for (int i = 0; i < 512; i++) begin
            do_txn(2'b11, (i % 2 == 0) ? 2'b01 : 2'b10, (i == 0) ? 1 : 2, 0);
        end
        req = '0;
        repeat (5) @(posedge clk);
        #1;
        chk("t5_done_cnt", 32'(done_cnt), 32'(1));
        chk("t5_done_prev_lfsr", 32'(done_prev), 32'(SEED_V));
        chk("t5_done_with_vv", 32'(done_vv), 32'(1));

`ifdef LFSR_SEED_LOAD_EN
        // Test 6: seed load in IDLE, zero maps to SEED, ignored during GEN
        begin
            logic [15:0] v6;
            logic [12:0] s6;
            seed_in   = 13'h0000;
            seed_load = 1'b1;
            @(posedge clk); #1;
            seed_load = 1'b0;
            chk("t6_zero_seed", 32'(lfsr), 32'(SEED_V));
            seed_in   = 13'h0ABC;
            seed_load = 1'b1;
            req       = 2'b01;
            @(posedge clk); #1;
            chk("t6_load_gnt", 32'(gnt), 32'(2'b01));
            chk("t6_load_val", 32'(lfsr), 32'(13'h0ABC));
            ml = 13'h0ABC;
            model_vec(v6, s6);
            seed_in = 13'h0001;
            w = 0;
            do begin @(posedge clk); #1; w++; end while (!vec_valid && w < 40);
            seed_load = 1'b0;
            req       = '0;
            chk("t6_vv_latency", 32'(w), 32'(VEC_W));
            chk("t6_vec", 32'(vec), 32'(v6));
            chk("t6_lfsr", 32'(lfsr), 32'(s6));
            repeat (3) @(posedge clk);
        end
`endif

        chk("gnt_multihot", 32'(multihot), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
